// File: rtl/cmp_window_stats.sv
// Windowed eq/gt/lt statistics collector behind a 4-bit comparator.
// Optional equal-run tracking is enabled with `define CMP_WIN_STREAK_EN.
module cmp_window_stats #(
  parameter int WIN   = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_equal,
  input  logic             in_gt,
  input  logic             in_lt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_eq_cnt,
  output logic [CNT_W-1:0] out_gt_cnt,
  output logic [CNT_W-1:0] out_lt_cnt,
  output logic [CNT_W-1:0] out_err_cnt,
  output logic [1:0]       out_majority,
  output logic [CNT_W-1:0] out_max_streak
);

  typedef enum logic {ACCUM, REPORT} state_t;

  state_t           r_state, w_state_n;
  logic [CNT_W-1:0] r_eq, r_gt, r_lt, r_err, r_smp;
  logic [CNT_W-1:0] w_eq_n, w_gt_n, w_lt_n, w_err_n;
  logic             w_acc, w_last, w_is_eq;
  logic [1:0]       w_maj;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ACCUM;
    else        r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    in_ready  = 1'b0;
    unique case (r_state)
      ACCUM: begin
        in_ready = ~clear;
        if (w_last) w_state_n = REPORT;
      end
      REPORT: begin
        if (out_ready) w_state_n = ACCUM;
      end
    endcase
    if (clear) w_state_n = ACCUM;
  end

  assign w_acc   = in_valid && in_ready;
  assign w_last  = w_acc && (r_smp == CNT_W'(WIN - 1));
  assign w_is_eq = ({in_equal, in_gt, in_lt} == 3'b100);

  always_comb begin
    w_eq_n  = r_eq;
    w_gt_n  = r_gt;
    w_lt_n  = r_lt;
    w_err_n = r_err;
    if (w_acc) begin
      case ({in_equal, in_gt, in_lt})
        3'b100:  w_eq_n  = sat_inc(r_eq);
        3'b010:  w_gt_n  = sat_inc(r_gt);
        3'b001:  w_lt_n  = sat_inc(r_lt);
        default: w_err_n = sat_inc(r_err);
      endcase
    end
  end

  // Ties favour eq, then gt; err is ignored.
  always_comb begin
    w_maj = 2'b10;
    if (w_eq_n >= w_gt_n && w_eq_n >= w_lt_n) w_maj = 2'b00;
    else if (w_gt_n >= w_lt_n)                w_maj = 2'b01;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_eq  <= '0;
      r_gt  <= '0;
      r_lt  <= '0;
      r_err <= '0;
      r_smp <= '0;
    end else if (clear || w_last) begin
      r_eq  <= '0;
      r_gt  <= '0;
      r_lt  <= '0;
      r_err <= '0;
      r_smp <= '0;
    end else if (w_acc) begin
      r_eq  <= w_eq_n;
      r_gt  <= w_gt_n;
      r_lt  <= w_lt_n;
      r_err <= w_err_n;
      r_smp <= sat_inc(r_smp);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_eq_cnt   <= '0;
      out_gt_cnt   <= '0;
      out_lt_cnt   <= '0;
      out_err_cnt  <= '0;
      out_majority <= 2'b00;
    end else if (clear) begin
      out_valid <= 1'b0;
    end else if (w_last) begin
      out_valid    <= 1'b1;
      out_eq_cnt   <= w_eq_n;
      out_gt_cnt   <= w_gt_n;
      out_lt_cnt   <= w_lt_n;
      out_err_cnt  <= w_err_n;
      out_majority <= w_maj;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef CMP_WIN_STREAK_EN
  logic [CNT_W-1:0] r_run, r_max;
  logic [CNT_W-1:0] w_run_n, w_max_n;

  always_comb begin
    w_run_n = r_run;
    if (w_acc) w_run_n = w_is_eq ? sat_inc(r_run) : '0;
    w_max_n = (w_run_n > r_max) ? w_run_n : r_max;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run          <= '0;
      r_max          <= '0;
      out_max_streak <= '0;
    end else if (clear) begin
      r_run <= '0;
      r_max <= '0;
    end else if (w_last) begin
      r_run          <= '0;
      r_max          <= '0;
      out_max_streak <= w_max_n;
    end else if (w_acc) begin
      r_run <= w_run_n;
      r_max <= w_max_n;
    end
  end
`else
  logic w_unused;
  assign w_unused       = w_is_eq;
  assign out_max_streak = '0;
`endif

endmodule
